l1_tag_store: RTL and testbench

//  Parametrised N-way tag store for the L1 cache: one 1R1W SRAM bank per way, each holding {valid,tag}.

---
 rtl/l1_tag_store_pkg.sv | 25 ++
 rtl/l1_tag_store_sram_bank.sv | 50 +++++
 rtl/l1_tag_store.sv | 197 +++++++++++++++++++
 tb/tb_l1_tag_store.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_tag_store_pkg.sv
// Shared types and helpers for the L1 tag store and its SRAM banks.
package l1_tag_store_pkg;

  localparam int TAG_W_DEFAULT = 18;
  localparam int SETS_DEFAULT  = 256;
  localparam int WAYS_DEFAULT  = 2;

  // One stored entry as seen by the cache controller at the default tag width.
  typedef struct packed {
    logic                     valid;
    logic [TAG_W_DEFAULT-1:0] tag;
  } tag_entry_t;

  // SWEEP clears every set in all ways; READY serves lookups and fills.
  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } tag_store_state_e;

  // Width of a way number; a direct-mapped store still carries one bit.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/l1_tag_store_sram_bank.sv
// One way of the tag store: a 1R1W SRAM with a registered read port.
// Read-during-write to the same address returns the old word.
module tag_sram_bank
  import l1_tag_store_pkg::*;
#(
  parameter int DATA_W = TAG_W_DEFAULT + 1,
  parameter int ADDR_W = $clog2(SETS_DEFAULT),
  parameter int DEPTH  = SETS_DEFAULT
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic csb0;
  logic csb1;

  assign csb0 = ~wr_en;
  assign csb1 = ~rd_en;

`ifdef OPENRAM_MACRO
  sram_1r1w_tag u_macro (
    .clk0  (clk),
    .csb0  (csb0),
    .addr0 (wr_addr),
    .din0  (wr_data),
    .clk1  (clk),
    .csb1  (csb1),
    .addr1 (rd_addr),
    .dout1 (rd_data)
  );
`else
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port (clk0 side of the macro).
  always_ff @(posedge clk) begin
    if (!csb0) mem[wr_addr] <= wr_data;
  end

  // Read port (clk1 side); a same-cycle write is not visible here.
  always_ff @(posedge clk) begin
    if (!csb1) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/l1_tag_store.sv
// N-way L1 tag store: invalidate sweep, two-cycle lookup pipeline with fill
// forwarding, and a per-set round-robin victim pointer.
module l1_tag_store
  import l1_tag_store_pkg::*;
#(
  parameter  int TAG_W = 18,
  parameter  int SETS  = 256,
  parameter  int WAYS  = 2,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = way_bits(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic [WAY_W-1:0] rsp_victim,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inv_all,
  output logic             busy
);

  tag_store_state_e state_q;
  tag_store_state_e state_d;
  logic [IDX_W-1:0] sweep_idx_q;
  logic             in_sweep;

  logic             accept;
  logic             inv_take;
  logic             fill_take;
  logic [WAY_W-1:0] fill_next;

  logic [WAY_W-1:0] rr_q [SETS];
  logic [WAY_W-1:0] rr_at_accept;

  logic [IDX_W-1:0] wr_addr;
  logic [TAG_W:0]   wr_word;
  logic [WAYS-1:0]  wr_en;
  logic [TAG_W:0]   rd_word [WAYS];

  logic             s1_valid;
  logic [IDX_W-1:0] s1_index;
  logic [TAG_W-1:0] s1_tag;
  logic [WAY_W-1:0] s1_victim;
  logic [WAYS-1:0]  s1_fwd;
  logic [TAG_W-1:0] s1_fwd_tag [WAYS];

  logic             eff_valid;
  logic [TAG_W-1:0] eff_tag;
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_cmp;

  assign in_sweep  = (state_q == SWEEP);
  assign accept    = lk_valid & lk_ready;
  assign inv_take  = inv_all & ~in_sweep;
  assign fill_take = fill_valid & ~in_sweep & ~inv_all;
  assign fill_next = (WAYS == 1) ? '0 : fill_way + WAY_W'(1);
  assign hit_any   = |hit_vec;

  // State register and sweep counter; the counter wraps to 0 at the end of a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_sweep) sweep_idx_q <= sweep_idx_q + IDX_W'(1);
      else if (inv_take) sweep_idx_q <= '0;
    end
  end

  // Next state: leave SWEEP after the last set, re-enter it on inv_all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SWEEP:   if (sweep_idx_q == IDX_W'(SETS - 1)) state_d = READY;
      READY:   if (inv_all) state_d = SWEEP;
      default: state_d = SWEEP;
    endcase
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    busy     = in_sweep;
    lk_ready = ~in_sweep;
  end

  // Shared write port: sweep clears every way, a fill writes only its way.
  always_comb begin
    wr_addr = in_sweep ? sweep_idx_q : fill_index;
    wr_word = in_sweep ? '0 : {1'b1, fill_tag};
    for (int w = 0; w < WAYS; w++) begin
      wr_en[w] = in_sweep | (fill_take & (fill_way == WAY_W'(w)));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    tag_sram_bank #(
      .DATA_W (TAG_W + 1),
      .ADDR_W (IDX_W),
      .DEPTH  (SETS)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en[g]),
      .wr_addr (wr_addr),
      .wr_data (wr_word),
      .rd_en   (accept),
      .rd_addr (lk_index),
      .rd_data (rd_word[g])
    );
  end

  assign rr_at_accept = (fill_take && (fill_index == lk_index)) ? fill_next : rr_q[lk_index];

  // Round-robin pointers: cleared by reset or invalidate, advanced past each filled way.
  always_ff @(posedge clk) begin
    if (rst || inv_take) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill_take) begin
      rr_q[fill_index] <= fill_next;
    end
  end

  // Stage 1: capture the request plus any same-cycle fill the SRAM read will miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_index  <= lk_index;
        s1_tag    <= lk_tag;
        s1_victim <= rr_at_accept;
        for (int w = 0; w < WAYS; w++) begin
          s1_fwd[w]     <= fill_take && (fill_index == lk_index) && (fill_way == WAY_W'(w));
          s1_fwd_tag[w] <= fill_tag;
        end
      end
    end
  end

  // Compare stage: SRAM data overridden by fills from the accept cycle and this cycle.
  always_comb begin
    hit_vec    = '0;
    hit_way    = '0;
    eff_valid  = 1'b0;
    eff_tag    = '0;
    victim_cmp = s1_victim;
    for (int w = 0; w < WAYS; w++) begin
      eff_valid = rd_word[w][TAG_W];
      eff_tag   = rd_word[w][TAG_W-1:0];
      if (s1_fwd[w]) begin
        eff_valid = 1'b1;
        eff_tag   = s1_fwd_tag[w];
      end
      if (fill_take && (fill_index == s1_index) && (fill_way == WAY_W'(w))) begin
        eff_valid = 1'b1;
        eff_tag   = fill_tag;
      end
      hit_vec[w] = eff_valid && (eff_tag == s1_tag);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    if (fill_take && (fill_index == s1_index)) victim_cmp = fill_next;
  end

  // Response registers; reset drops anything still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_victim <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_hit    <= hit_any;
        rsp_way    <= hit_way;
        rsp_victim <= victim_cmp;
      end
    end
  end

  // A tag present in two ways of one set means the controller filled a duplicate.
  a_single_hit: assert property (@(posedge clk) disable iff (rst) s1_valid |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_l1_tag_store.sv
// Self-checking bench for l1_tag_store: directed scenarios followed by random
// traffic, all compared against a set/way array model of the cache tags.
module tb_l1_tag_store;

  localparam int TAG_W = 18;
  localparam int SETS  = 256;
  localparam int WAYS  = 2;
  localparam int IDX_W = 8;
  localparam int WAY_W = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             lk_valid;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_index;
  logic [TAG_W-1:0] lk_tag;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic [WAY_W-1:0] rsp_victim;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [WAY_W-1:0] fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             inv_all;
  logic             busy;

  l1_tag_store #(
    .TAG_W (TAG_W),
    .SETS  (SETS),
    .WAYS  (WAYS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_index   (lk_index),
    .lk_tag     (lk_tag),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_way    (rsp_way),
    .rsp_victim (rsp_victim),
    .fill_valid (fill_valid),
    .fill_index (fill_index),
    .fill_way   (fill_way),
    .fill_tag   (fill_tag),
    .inv_all    (inv_all),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: what each set holds, its victim pointer, and sweep cycles left.
  bit               m_valid [SETS][WAYS];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  int               m_rr    [SETS];
  int               sweep_left;

  typedef struct {
    bit               v;
    bit               done;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    bit               hit;
    int               way;
    int               victim;
  } lk_t;

  lk_t pend;
  int  passed;
  int  failed;
  int  total;

  function automatic void clear_model();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
      m_rr[s] = 0;
    end
  endfunction

  function automatic lk_t evaluate(input lk_t l);
    lk_t r;
    r        = l;
    r.hit    = 1'b0;
    r.way    = 0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m_valid[l.idx][w] && (m_tag[l.idx][w] == l.tag)) begin
        r.hit = 1'b1;
        r.way = w;
      end
    end
    r.victim = m_rr[l.idx];
    r.done   = 1'b1;
    return r;
  endfunction

  function automatic bit tag_elsewhere(input logic [IDX_W-1:0] i, input int way, input logic [TAG_W-1:0] t);
    for (int w = 0; w < WAYS; w++) begin
      if ((w != way) && m_valid[i][w] && (m_tag[i][w] == t)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // One clock of stimulus; the model advances alongside and the response due this cycle is checked.
  task automatic apply_stimulus(input bit r, input bit lv, input logic [IDX_W-1:0] li,
                                input logic [TAG_W-1:0] lt, input bit fv, input logic [IDX_W-1:0] fi,
                                input logic [WAY_W-1:0] fw, input logic [TAG_W-1:0] ft, input bit inv);
    lk_t cur;
    bit  ready_now;
    cur        = '{default: 0};
    rst        = r;
    lk_valid   = lv;
    lk_index   = li;
    lk_tag     = lt;
    fill_valid = fv;
    fill_index = fi;
    fill_way   = fw;
    fill_tag   = ft;
    inv_all    = inv;
    if (r) begin
      clear_model();
      sweep_left = SETS;
      pend       = '{default: 0};
    end else begin
      ready_now = (sweep_left == 0);
      check_output("lk_ready", {31'd0, lk_ready}, {31'd0, ready_now});
      check_output("busy", {31'd0, busy}, {31'd0, !ready_now});
      if (lv && ready_now) begin
        cur.v   = 1'b1;
        cur.idx = li;
        cur.tag = lt;
      end
      if (ready_now && inv) begin
        if (pend.v && !pend.done) pend = evaluate(pend);
        if (cur.v) cur = evaluate(cur);
        clear_model();
        sweep_left = SETS;
      end else begin
        if (ready_now && fv) begin
          m_valid[fi][fw] = 1'b1;
          m_tag[fi][fw]   = ft;
          m_rr[fi]        = (int'(fw) + 1) % WAYS;
        end
        if (pend.v && !pend.done) pend = evaluate(pend);
        if (!ready_now) sweep_left--;
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      check_output("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check_output("reset_rsp_hit", {31'd0, rsp_hit}, 32'd0);
      check_output("reset_rsp_way", {31'd0, rsp_way}, 32'd0);
      check_output("reset_rsp_victim", {31'd0, rsp_victim}, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd1);
      check_output("reset_lk_ready", {31'd0, lk_ready}, 32'd0);
    end else begin
      check_output("rsp_valid", {31'd0, rsp_valid}, {31'd0, pend.v});
      if (pend.v) begin
        check_output("rsp_hit", {31'd0, rsp_hit}, {31'd0, pend.hit});
        check_output("rsp_way", {31'd0, rsp_way}, pend.way);
        check_output("rsp_victim", {31'd0, rsp_victim}, pend.victim);
      end
    end
    pend = cur;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic lookup(input logic [IDX_W-1:0] i, input logic [TAG_W-1:0] t);
    apply_stimulus(1'b0, 1'b1, i, t, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic fill(input logic [IDX_W-1:0] i, input logic [WAY_W-1:0] w, input logic [TAG_W-1:0] t);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, i, w, t, 1'b0);
  endtask

  task automatic invalidate();
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
  endtask

  // Idle until busy drops, bounded so a stuck sweep still reaches the summary.
  task automatic wait_sweep(output int n);
    n = 0;
    while ((busy === 1'b1) && (n < 400)) begin
      idle();
      n++;
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n;
    bit r_r, r_lv, r_fv, r_inv;
    logic [IDX_W-1:0] r_li, r_fi;
    logic [TAG_W-1:0] r_lt, r_ft;
    logic [WAY_W-1:0] r_fw;

    passed = 0;
    failed = 0;
    total  = 0;
    pend   = '{default: 0};
    clear_model();

    $display("[TB] reset and initial sweep");
    do_reset();
    wait_sweep(n);
    check_output("sweep_len_after_reset", n, 32'd256);
    lookup(8'd5, 18'h123);
    idle();
    check_output("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("t1_miss", {31'd0, rsp_hit}, 32'd0);

    $display("[TB] fill then hit");
    fill(8'd5, 1'b1, 18'h123);
    idle();
    lookup(8'd5, 18'h123);
    lookup(8'd5, 18'h124);
    check_output("t2_hit", {31'd0, rsp_hit}, 32'd1);
    check_output("t2_way", {31'd0, rsp_way}, 32'd1);
    idle();
    check_output("t2_other_tag_miss", {31'd0, rsp_hit}, 32'd0);

    $display("[TB] forwarding");
    lookup(8'd9, 18'h7);
    fill(8'd9, 1'b0, 18'h7);
    check_output("t3_fwd_hit", {31'd0, rsp_hit}, 32'd1);
    check_output("t3_fwd_way", {31'd0, rsp_way}, 32'd0);
    lookup(8'd10, 18'h7);
    idle();
    check_output("t3_late_fill_miss", {31'd0, rsp_hit}, 32'd0);
    fill(8'd10, 1'b0, 18'h7);
    apply_stimulus(1'b0, 1'b1, 8'd11, 18'h55, 1'b1, 8'd11, 1'b1, 18'h55, 1'b0);
    idle();
    check_output("t3_same_cycle_hit", {31'd0, rsp_hit}, 32'd1);
    check_output("t3_same_cycle_way", {31'd0, rsp_way}, 32'd1);

    $display("[TB] round-robin victim");
    fill(8'd3, 1'b0, 18'h30);
    idle();
    lookup(8'd3, 18'h30);
    idle();
    check_output("t4_victim_after_way0", {31'd0, rsp_victim}, 32'd1);
    fill(8'd3, 1'b1, 18'h31);
    idle();
    lookup(8'd3, 18'h31);
    lookup(8'd4, 18'h0);
    check_output("t4_victim_after_way1", {31'd0, rsp_victim}, 32'd0);
    idle();
    check_output("t4_other_set_victim", {31'd0, rsp_victim}, 32'd0);

    $display("[TB] back-to-back lookups");
    lookup(8'd5, 18'h123);
    lookup(8'd5, 18'h1);
    check_output("t5_first_hit", {31'd0, rsp_hit}, 32'd1);
    lookup(8'd9, 18'h7);
    check_output("t5_second_miss", {31'd0, rsp_hit}, 32'd0);
    lookup(8'd3, 18'h31);
    check_output("t5_third_way", {31'd0, rsp_way}, 32'd0);
    check_output("t5_third_hit", {31'd0, rsp_hit}, 32'd1);
    idle();
    check_output("t5_fourth_valid", {31'd0, rsp_valid}, 32'd1);
    check_output("t5_fourth_way", {31'd0, rsp_way}, 32'd1);

    $display("[TB] invalidate");
    apply_stimulus(1'b0, 1'b1, 8'd5, 18'h123, 1'b1, 8'd6, 1'b0, 18'h66, 1'b1);
    idle();
    check_output("t6_preinv_lookup_hit", {31'd0, rsp_hit}, 32'd1);
    wait_sweep(n);
    check_output("sweep_len_after_inv", n + 1, 32'd256);
    lookup(8'd5, 18'h123);
    idle();
    check_output("t6_postinv_miss", {31'd0, rsp_hit}, 32'd0);
    lookup(8'd6, 18'h66);
    idle();
    check_output("t6_dropped_fill_miss", {31'd0, rsp_hit}, 32'd0);

    $display("[TB] reset mid-lookup and mid-sweep");
    lookup(8'd1, 18'h0);
    do_reset();
    repeat (100) idle();
    do_reset();
    wait_sweep(n);
    check_output("sweep_len_after_midsweep_reset", n, 32'd256);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      r_r   = ($urandom_range(999) == 0);
      r_inv = ($urandom_range(299) == 0);
      r_lv  = ($urandom_range(9) < 7);
      r_fv  = ($urandom_range(9) < 4);
      r_li  = IDX_W'($urandom_range(3));
      r_lt  = TAG_W'($urandom_range(3));
      r_fi  = IDX_W'($urandom_range(3));
      r_fw  = WAY_W'($urandom_range(1));
      r_ft  = TAG_W'($urandom_range(3));
      if (r_fv && tag_elsewhere(r_fi, int'(r_fw), r_ft)) r_fv = 1'b0;
      apply_stimulus(r_r, r_lv, r_li, r_lt, r_fv, r_fi, r_fw, r_ft, r_inv);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
